// File: rtl/dsp_meas_pkg.sv
// Shared definitions for the error-measurement control slice: state
// encoding and common widths used by the controller and its counters.
package dsp_meas_pkg;

    // Width of the averaged error and squared-error words (2s16 format)
    localparam int ERR_W    = 18;

    // Width of the settle-phase symbol counter
    localparam int SETTLE_W = 16;

    // Measurement sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_ACCUM   = 3'd3,
        ST_DUMP    = 3'd4,
        ST_CAPTURE = 3'd5
    } meas_state_t;

endpackage

// File: rtl/sym_window_cnt.sv
// Loadable symbol up-counter with enable and a terminal-count flag.
// tc is combinational and marks the enabled cycle whose increment makes
// the count equal term_val, so the owner can leave on the same edge.
module sym_window_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_inc;

    // Next count: load takes priority over counting; flag the terminal step
    always_comb begin
        cnt_inc = cnt_q + WIDTH'(1);
        cnt_d   = cnt_q;
        tc      = 1'b0;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_inc;
            tc    = (cnt_inc == term_val);
        end
    end

    // Count register, cleared by the system reset
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/err_meas_ctrl.sv
// Sequencer for the mean-error and mean-squared-error accumulators.
// Flushes the accumulators, discards a settle period, gates exactly
// 2^WIN_LOG2 symbols into them, dumps, captures both averages and offers
// them to the host over a valid/ready handshake. Single-shot or continuous.
module err_meas_ctrl
    import dsp_meas_pkg::*;
#(
    parameter int WIN_LOG2    = 22,
    parameter int SETTLE_SYMS = 16
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    sym_clk_en,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    cont,
    input  logic signed [ERR_W-1:0] err_acc_in,
    input  logic signed [ERR_W-1:0] err_sq_in,
    output logic                    acc_en,
    output logic                    clr_acc,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic signed [ERR_W-1:0] err_mean,
    output logic signed [ERR_W-1:0] err_msq,
    output logic                    busy,
    output logic                    overrun,
    output logic [WIN_LOG2:0]       win_cnt
);

    localparam logic [WIN_LOG2:0]   WIN_LEN     = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [SETTLE_W-1:0] SETTLE_TERM = SETTLE_W'(SETTLE_SYMS);

    meas_state_t state_q, state_d;
    logic        abort_pend_q, abort_pend_d;
    logic        result_valid_q, result_valid_d;
    logic        overrun_q, overrun_d;
    logic signed [ERR_W-1:0] err_mean_q, err_mean_d;
    logic signed [ERR_W-1:0] err_msq_q, err_msq_d;

    logic                in_settle;
    logic                in_accum;
    logic                settle_load;
    logic                settle_done;
    logic                win_load;
    logic                win_done;
    logic [SETTLE_W-1:0] settle_cnt_unused;

    assign in_settle   = (state_q == ST_SETTLE);
    assign in_accum    = (state_q == ST_ACCUM);
    assign settle_load = (state_q == ST_FLUSH);

    // The window count restarts whenever ACCUM is entered, from settle or
    // from a continuous-mode capture, and otherwise holds its last value
    assign win_load = (state_d == ST_ACCUM) && (state_q != ST_ACCUM);

    sym_window_cnt #(
        .WIDTH (SETTLE_W)
    ) u_settle_cnt (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .load     (settle_load),
        .load_val ('0),
        .en       (in_settle && sym_clk_en),
        .term_val (SETTLE_TERM),
        .cnt      (settle_cnt_unused),
        .tc       (settle_done)
    );

    sym_window_cnt #(
        .WIDTH (WIN_LOG2 + 1)
    ) u_win_cnt (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .load     (win_load),
        .load_val ('0),
        .en       (in_accum && sym_clk_en),
        .term_val (WIN_LEN),
        .cnt      (win_cnt),
        .tc       (win_done)
    );

    // State sequencing; an abort during dump/capture is remembered so the
    // pending result is still delivered before returning to idle
    always_comb begin
        state_d      = state_q;
        abort_pend_d = abort_pend_q;
        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (start && !abort) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = (abort_pend_q || abort) ? ST_IDLE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                    state_d      = ST_FLUSH;
                end else if (settle_done) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                    state_d      = ST_FLUSH;
                end else if (win_done) begin
                    state_d = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (abort_pend_q || abort || !cont) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result registers and handshake; a capture in the same cycle as ready
    // replaces the consumed result without flagging an overrun
    always_comb begin
        result_valid_d = result_valid_q;
        overrun_d      = overrun_q;
        err_mean_d     = err_mean_q;
        err_msq_d      = err_msq_q;
        if (result_valid_q && result_ready) begin
            result_valid_d = 1'b0;
        end
        if (state_q == ST_CAPTURE) begin
            result_valid_d = 1'b1;
            err_mean_d     = err_acc_in;
            err_msq_d      = err_sq_in;
            if (result_valid_q && !result_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    // Controller registers; reset discards any measurement in progress
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            abort_pend_q   <= 1'b0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            err_mean_q     <= '0;
            err_msq_q      <= '0;
        end else begin
            state_q        <= state_d;
            abort_pend_q   <= abort_pend_d;
            result_valid_q <= result_valid_d;
            overrun_q      <= overrun_d;
            err_mean_q     <= err_mean_d;
            err_msq_q      <= err_msq_d;
        end
    end

    assign acc_en       = in_accum && sym_clk_en;
    assign clr_acc      = (state_q == ST_FLUSH) || (state_q == ST_DUMP);
    assign busy         = (state_q != ST_IDLE);
    assign result_valid = result_valid_q;
    assign overrun      = overrun_q;
    assign err_mean     = err_mean_q;
    assign err_msq      = err_msq_q;

endmodule

// File: doc/err_meas_ctrl.md
Name: err_meas_ctrl

Overview:
- Sequences the error-statistics accumulators: the mean-error accumulator and the mean-squared-error accumulator.
- Drives their shared symbol enable and clr_acc strobe, and counts symbols over a measurement window of 2^WIN_LOG2 symbols.
- Captures both averaged results and hands them to the host/MER logic over a valid/ready handshake.
- Sits between the symbol-timing generator and the two accumulator instances. Supports single-shot and continuous measurement.

Parameters:
- WIN_LOG2, 22, log2 of window length in symbols; must equal the accumulators' LFSR_WID.
- SETTLE_SYMS, 16, symbols discarded after start before accumulation begins (1..2^16-1).

Ports:
- sys_clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sym_clk_en  in  1  one-sys_clk-wide symbol strobe
- start  in  1  begin measurement (sampled in IDLE only)
- abort  in  1  terminate measurement, discard result
- cont  in  1  continuous mode; sampled at each window end
- err_acc_in  in  18 s  averaged error from the mean-error accumulator, 2s16
- err_sq_in  in  18 s  averaged squared error from the MSE accumulator
- acc_en  out  1  gated symbol enable to both accumulators
- clr_acc  out  1  dump/clear strobe to both accumulators
- result_valid  out  1  result registers hold an unconsumed result
- result_ready  in  1  consumer accepts result
- err_mean  out  18 s  captured mean error
- err_msq  out  18 s  captured mean squared error
- busy  out  1  state != IDLE
- overrun  out  1  sticky: a result was overwritten before it was consumed
- win_cnt  out  WIN_LOG2+1  symbols accumulated in the current window

Behaviour:
- Reset (synchronous, active-high, sys_clk):
  - State goes to IDLE.
  - All outputs are 0: acc_en, clr_acc, result_valid, err_mean, err_msq, overrun, win_cnt.
  - Reset mid-window discards everything. No clr_acc is issued, because the accumulators reset themselves.
- States: IDLE, FLUSH, SETTLE, ACCUM, DUMP, CAPTURE.
- IDLE:
  - start=1 and abort=0 -> FLUSH.
- FLUSH (1 cycle):
  - clr_acc=1. The accumulators clear on its falling edge.
  - Goes to SETTLE.
- SETTLE:
  - Counts sym_clk_en pulses; acc_en stays 0.
  - After SETTLE_SYMS pulses -> ACCUM, with win_cnt=0.
- ACCUM:
  - acc_en = sym_clk_en, combinational, valid only in ACCUM.
  - win_cnt increments on each sym_clk_en.
  - On the sym_clk_en cycle where win_cnt becomes 2^WIN_LOG2 -> DUMP on the next edge. That final symbol is accumulated.
- DUMP (1 cycle):
  - clr_acc=1; acc_en=0.
  - The accumulators load their outputs at this edge and clear on the falling edge of clr_acc.
  - Goes to CAPTURE.
- CAPTURE (1 cycle):
  - Registers err_acc_in -> err_mean and err_sq_in -> err_msq at the edge ending this cycle.
  - result_valid=1 from the following cycle.
  - If result_valid is already 1 and result_ready=0 in this cycle: overwrite and set overrun (sticky until reset).
  - Next state: cont=1 -> ACCUM with win_cnt=0 (no re-settle); otherwise -> IDLE.
- Latency: first result_valid = 2 cycles after the final window symbol (DUMP, CAPTURE, then valid).
- sym_clk_en pulses arriving in FLUSH, DUMP or CAPTURE are dropped, not accumulated and not counted. This is documented; symbol spacing is at least 4 sys_clk.
- Handshake:
  - result_valid clears on the cycle after result_valid & result_ready.
  - err_mean and err_msq hold until the next CAPTURE.
  - A simultaneous CAPTURE and ready consumes the old result; valid stays 1 with the new data, and overrun is not set.
- Abort:
  - In SETTLE or ACCUM -> FLUSH-abort: one cycle of clr_acc=1, then IDLE.
  - No capture; result registers and result_valid are untouched.
  - Abort in DUMP or CAPTURE is deferred until after CAPTURE; the result is still delivered, then IDLE regardless of cont.
  - Abort in IDLE is ignored. start and abort together: abort wins, stays IDLE.
- start outside IDLE is ignored.
- Counters:
  - SETTLE counter is 16 bits.
  - win_cnt is WIN_LOG2+1 bits, so it reaches exactly 2^WIN_LOG2 without wrap.
  - win_cnt holds its final value in DUMP/CAPTURE/IDLE until the next ACCUM entry.

Decomposition:
- Shared package `dsp_meas_pkg` holds:
  - state enum `meas_state_t`
  - constant ERR_W=18
  - constant SETTLE_W=16
- One natural sub-module, `sym_window_cnt`: a loadable up-counter with enable and terminal-count flag, instanced for both the settle and window counts.

Test Plan:
Setup for all cases: WIN_LOG2=4, SETTLE_SYMS=2, sym_clk_en every 4th cycle, err_acc_in=18'sd100, err_sq_in=18'sd500.
- Single shot: start pulse ->
  - clr_acc 1 cycle
  - 2 symbols with acc_en=0
  - exactly 16 acc_en pulses
  - clr_acc 1 cycle
  - result_valid 2 cycles after the 16th symbol; err_mean=100, err_msq=500
  - busy falls.
- Continuous: cont=1, result_ready=1 always ->
  - a result every 16 symbols plus DUMP/CAPTURE, no re-settle
  - overrun stays 0.
- Overrun: cont=1, result_ready=0 -> second CAPTURE sets overrun=1 and err_mean takes the new value. Then ready=1 -> valid clears 1 cycle later.
- Abort at win_cnt=7:
  - one clr_acc cycle, then IDLE
  - result_valid unchanged (0)
  - acc_en never high afterwards.
- Start+abort simultaneous in IDLE -> state stays IDLE, busy=0, no clr_acc.
- Reset asserted mid-ACCUM (win_cnt=9) -> next cycle all outputs 0, no clr_acc. A subsequent start gives a full 16-symbol window.
